// File: rtl/circular_convolution_pkg.sv
// Shared types and helpers for the multi-lane circular convolution engine.
// Define CIRCULAR_CONVOLUTION_SAT_EN to saturate results instead of wrapping.
package circular_convolution_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Accumulator width that cannot overflow for n signed qlen x qlen products.
    function automatic int unsigned calc_acc_w(input int unsigned qlen, input int unsigned n);
        return 2 * qlen + $clog2(n);
    endfunction

    function automatic int unsigned calc_steps(input int unsigned n, input int unsigned lanes);
        return n / lanes;
    endfunction

    // Reduce a sign-extended sum to qlen bits; the caller keeps the qlen LSBs.
    function automatic logic signed [63:0] reduce_sum(input logic signed [63:0] v,
                                                      input int unsigned qlen);
`ifdef CIRCULAR_CONVOLUTION_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (qlen - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (qlen - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return v & ((64'sd1 <<< qlen) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/circular_convolution_par_dot.sv
// One convolution lane: N signed MACs, arithmetic shift by FRAC, then wrap or saturate.
// Saturation is selected by CIRCULAR_CONVOLUTION_SAT_EN (see package).
module conv_dot_product
    import circular_convolution_pkg::*;
#(
    parameter int unsigned QLEN        = 16,
    parameter int unsigned WINDOW_SIZE = 16,
    parameter int unsigned FRAC        = 0
) (
    input  logic [WINDOW_SIZE-1:0][QLEN-1:0] i_weights,
    input  logic [WINDOW_SIZE-1:0][QLEN-1:0] i_data,
    output logic [QLEN-1:0]                  o_result_c
);

    localparam int unsigned ACC_W  = calc_acc_w(QLEN, WINDOW_SIZE);
    localparam int unsigned PROD_W = 2 * QLEN;

    logic signed [PROD_W-1:0] w_prod [WINDOW_SIZE];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [63:0]       w_ext;

    for (genvar j = 0; j < WINDOW_SIZE; j++) begin : g_mac
        assign w_prod[j] = PROD_W'($signed(i_weights[j])) * PROD_W'($signed(i_data[j]));
    end

    always_comb begin
        w_acc = '0;
        for (int j = 0; j < WINDOW_SIZE; j++) begin
            w_acc = w_acc + ACC_W'(w_prod[j]);
        end
    end

    assign w_shifted  = w_acc >>> FRAC;
    assign w_ext      = 64'(w_shifted);
    assign o_result_c = QLEN'(reduce_sum(w_ext, QLEN));

endmodule

// File: rtl/circular_convolution_par.sv
// Multi-lane circular convolution: accepts a frame + weights, produces LANES outputs per cycle,
// holds the result frame under back-pressure. Optional saturation via CIRCULAR_CONVOLUTION_SAT_EN.
module circular_convolution_par
    import circular_convolution_pkg::*;
#(
    parameter int unsigned QLEN        = 16,
    parameter int unsigned WINDOW_SIZE = 16,
    parameter int unsigned LANES       = 4,
    parameter int unsigned FRAC        = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WINDOW_SIZE-1:0][QLEN-1:0] weights,
    input  logic [WINDOW_SIZE-1:0][QLEN-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WINDOW_SIZE-1:0][QLEN-1:0] out_data
);

    localparam int unsigned STEPS  = calc_steps(WINDOW_SIZE, LANES);
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IDX_W  = $clog2(WINDOW_SIZE);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    if (WINDOW_SIZE < 2) begin : g_bad_window
        $error("circular_convolution_par: WINDOW_SIZE must be >= 2");
    end
    if ((WINDOW_SIZE % LANES) != 0) begin : g_bad_lanes
        $error("circular_convolution_par: WINDOW_SIZE must be a multiple of LANES");
    end

    state_t                           r_state;
    logic [STEP_W-1:0]                r_step;
    logic [WINDOW_SIZE-1:0][QLEN-1:0] r_data;
    logic [WINDOW_SIZE-1:0][QLEN-1:0] r_weights;
    logic [WINDOW_SIZE-1:0][QLEN-1:0] r_out_data;
    logic                             r_out_valid;
    logic [QLEN-1:0]                  w_lane_res [LANES];

    // Lane l sees the data register rotated down by l, so it produces y[s*LANES+l].
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WINDOW_SIZE-1:0][QLEN-1:0] w_rot;
        for (genvar j = 0; j < WINDOW_SIZE; j++) begin : g_rot
            assign w_rot[j] = r_data[(j + l) % WINDOW_SIZE];
        end
        conv_dot_product #(
            .QLEN        (QLEN),
            .WINDOW_SIZE (WINDOW_SIZE),
            .FRAC        (FRAC)
        ) u_dot (
            .i_weights  (r_weights),
            .i_data     (w_rot),
            .o_result_c (w_lane_res[l])
        );
    end

    assign in_ready  = ~rst & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_data      <= '0;
            r_weights   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data    <= in_data;
                        r_weights <= weights;
                        r_step    <= '0;
                        r_state   <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    for (int k = 0; k < WINDOW_SIZE; k++) begin
                        if (STEP_W'(k / LANES) == r_step) begin
                            r_out_data[IDX_W'(k)] <= w_lane_res[LANE_W'(k % LANES)];
                        end
                    end
                    for (int i = 0; i < WINDOW_SIZE; i++) begin
                        r_data[IDX_W'(i)] <= r_data[IDX_W'((i + LANES) % WINDOW_SIZE)];
                    end
                    if (r_step == STEP_W'(STEPS - 1)) begin
                        r_step      <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_data    <= in_data;
                            r_weights <= weights;
                            r_step    <= '0;
                            r_state   <= ST_COMPUTE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circular_convolution_par.sv
// Directed self-checking bench for circular_convolution_par (default instance plus LANES=1, FRAC=8).
module tb_circular_convolution_par;

    localparam int unsigned N = 16;
    localparam int unsigned Q = 16;

    typedef logic [N-1:0][Q-1:0] frame_t;
    typedef struct {
        frame_t w;
        frame_t x;
        frame_t y;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   in_valid = 1'b0;
    logic   in_ready;
    frame_t weights = '0;
    frame_t in_data = '0;
    logic   out_valid;
    logic   out_ready = 1'b1;
    frame_t out_data;

    logic   in_valid2 = 1'b0;
    logic   in_ready2;
    logic   out_valid2;
    logic   out_ready2 = 1'b1;
    frame_t out_data2;

    int errors = 0;
    int checks = 0;

    vec_t tbl [6];

    always #5 clk = ~clk;

    circular_convolution_par #(.QLEN(Q), .WINDOW_SIZE(N), .LANES(4), .FRAC(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weights   (weights),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    circular_convolution_par #(.QLEN(Q), .WINDOW_SIZE(N), .LANES(1), .FRAC(8)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .weights   (weights),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2)
    );

    task automatic chk(input string name, input logic [N*Q-1:0] got, input logic [N*Q-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Direct evaluation of y[k] = sum_j w[j]*x[(j+k) mod N] with FRAC=0.
    function automatic frame_t ref_conv(input frame_t w, input frame_t x);
        frame_t y;
        longint acc;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                acc += longint'($signed(w[j])) * longint'($signed(x[(j + k) % N]));
            end
`ifdef CIRCULAR_CONVOLUTION_SAT_EN
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
`endif
            y[k] = 16'(acc);
        end
        return y;
    endfunction

    // Offer a frame, scramble the inputs right after acceptance, then time and check the result.
    task automatic run_frame(input string name, input frame_t w, input frame_t x,
                             input frame_t y, input int exp_lat);
        int lat;
        int guard;
        @(negedge clk);
        weights  = w;
        in_data  = x;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " accept"}, N*Q'(in_ready), N*Q'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        weights  = ~w;
        in_data  = ~x;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, N*Q'(lat), N*Q'(exp_lat));
        chk({name, " data"}, out_data, y);
    endtask

    initial begin
        frame_t ya;
        frame_t yb;
        frame_t ones;
        frame_t ramp;
        frame_t delta_w;
        int lat;

        for (int k = 0; k < N; k++) begin
            ramp[k]    = 16'(k);
            ones[k]    = 16'd1;
            delta_w[k] = (k == 0) ? 16'd1 : 16'd0;
        end

        tbl[0].w = delta_w;
        tbl[0].x = ramp;
        tbl[0].y = ramp;
        tbl[1].w = ones;
        tbl[1].x = ones;
        for (int k = 0; k < N; k++) tbl[1].y[k] = 16'd16;
        tbl[2].w = ramp;
        tbl[2].x = delta_w;
        for (int k = 0; k < N; k++) tbl[2].y[k] = 16'((N - k) % N);
        tbl[3].w = '0;
        tbl[3].w[0] = 16'hFFFF;
        tbl[3].x = ramp;
        for (int k = 0; k < N; k++) tbl[3].y[k] = 16'(-k);
        for (int k = 0; k < N; k++) begin
            tbl[4].w[k] = 16'h7FFF;
            tbl[4].x[k] = 16'h7FFF;
`ifdef CIRCULAR_CONVOLUTION_SAT_EN
            tbl[4].y[k] = 16'h7FFF;
`else
            tbl[4].y[k] = 16'h0010;
`endif
        end
        for (int k = 0; k < N; k++) begin
            tbl[5].w[k] = 16'($urandom);
            tbl[5].x[k] = 16'($urandom);
        end
        tbl[5].y = ref_conv(tbl[5].w, tbl[5].x);

        // Reset behaviour
        @(negedge clk);
        chk("rst in_ready", N*Q'(in_ready), '0);
        chk("rst out_valid", N*Q'(out_valid), '0);
        chk("rst out_data", out_data, '0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", N*Q'(in_ready), N*Q'(1));

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].x, tbl[i].y, 4);
        end

        // Back-pressure: result held, new frame refused, then simultaneous handshake + accept
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        ya = ramp;
        run_frame("bp_a", delta_w, ramp, ya, 4);
        @(negedge clk);
        weights  = ones;
        in_data  = ones;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold valid c%0d", c), N*Q'(out_valid), N*Q'(1));
            chk($sformatf("bp hold data c%0d", c), out_data, ya);
            chk($sformatf("bp in_ready c%0d", c), N*Q'(in_ready), '0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", N*Q'(in_ready), N*Q'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp handshake valid drop", N*Q'(out_valid), '0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int k = 0; k < N; k++) yb[k] = 16'd16;
        chk("bp next latency", N*Q'(lat), N*Q'(4));
        chk("bp next data", out_data, yb);

        // Reset in the middle of COMPUTE
        @(negedge clk);
        weights  = ones;
        in_data  = ones;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst out_valid", N*Q'(out_valid), '0);
        chk("midrst out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst in_ready", N*Q'(in_ready), N*Q'(1));
        run_frame("after_rst", delta_w, ramp, ramp, 4);

        // Single-lane, FRAC=8 instance: 0x0100 * k >>> 8 == k, 16-cycle latency
        repeat (2) @(negedge clk);
        weights    = '0;
        weights[0] = 16'h0100;
        in_data    = ramp;
        in_valid2  = 1'b1;
        chk("l1 in_ready", N*Q'(in_ready2), N*Q'(1));
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("l1 latency", N*Q'(lat), N*Q'(16));
        chk("l1 data", out_data2, ramp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
